// File: rtl/j_jmem_pkg.sv
// Shared definitions for the DSP external-memory arbiter and its helpers.
package j_jmem_pkg;

  localparam int NREQ_MAX = 4;

  localparam int RQ_FETCH = 0;
  localparam int RQ_LDST  = 1;
  localparam int RQ_BLK   = 2;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_OWN  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/j_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upwards, wrapping modulo N.
module j_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  logic [IW:0] cand;

  // NOTE: every combinational output gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!vld && req[cand[IW-1:0]]) begin
        vld = 1'b1;
        idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/j_jmem_arb.sv
// Arbiter/sequencer sharing the DSP external-memory master port between the
// fetch, load/store and block-move requesters; also owns the system bus request.
module j_jmem_arb
  import j_jmem_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = 24,
  parameter int HOLD = 4,
  parameter int TMO  = 255
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [3*NREQ-1:0] req_w,
  input  logic [AW*NREQ-1:0] req_a,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              mreq,
  output logic              rw,
  output logic [2:0]        w,
  output logic [AW-1:0]     a,
  input  logic              ack,
  input  logic              dbgl,
  output logic              breql,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_L = HW'(HOLD);
  localparam logic [7:0]    TMO_L  = 8'(TMO);

  bus_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            sel_v_q, sel_v_d;
  logic [IW-1:0]   sel_idx_q, sel_idx_d;
  logic            out_v_q, out_v_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            rw_q, rw_d;
  logic [2:0]      w_q, w_d;
  logic [AW-1:0]   a_q, a_d;
  logic            mreq_q, mreq_d;
  logic            breql_q, breql_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [7:0]      wd_q, wd_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] elig;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            activity;
  logic            accept;
  logic            complete;

  // The outstanding owner and anyone whose gnt is still pulsing are excluded,
  // so a held-high req is never picked twice for the same transfer.
  assign own_oh   = NREQ'(1) << owner_q;
  assign elig     = req & ~gnt_q & ~(out_v_q ? own_oh : '0);
  assign activity = (|req) | sel_v_q | out_v_q;
  assign accept   = mreq_q & ack;
  assign complete = out_v_q & ack;

  j_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_v_d   = sel_v_q;
    sel_idx_d = sel_idx_q;
    out_v_d   = out_v_q;
    owner_d   = owner_q;
    rw_d      = rw_q;
    w_d       = w_q;
    a_d       = a_q;
    hold_d    = hold_q;
    wd_d      = wd_q;
    err_d     = err_q;
    gnt_d     = '0;
    done_d    = '0;

    case (state_q)
      BUS_IDLE: if (activity) state_d = BUS_REQ;
      BUS_REQ:  if (!dbgl) state_d = BUS_OWN;
      BUS_OWN: begin
        if (activity) begin
          hold_d = HOLD_L;
        end else if (hold_q <= HW'(1)) begin
          state_d = BUS_IDLE;
          hold_d  = HOLD_L;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = BUS_IDLE;
    endcase

    // Completion is handled first so a same-edge acceptance overrides out_v.
    if (complete) begin
      done_d  = own_oh;
      out_v_d = 1'b0;
    end

    if (accept) begin
      gnt_d   = NREQ'(1) << sel_idx_q;
      owner_d = sel_idx_q;
      out_v_d = 1'b1;
      sel_v_d = 1'b0;
      ptr_d   = (sel_idx_q == IW'(NREQ - 1)) ? '0 : sel_idx_q + 1'b1;
      wd_d    = '0;
    end else if (out_v_q && !ack && wd_q != 8'hFF) begin
      wd_d = wd_q + 1'b1;
    end

    if (TMO != 0 && out_v_q && !ack && wd_d >= TMO_L) err_d = 1'b1;

    if (!sel_v_q && pick_vld) begin
      sel_v_d   = 1'b1;
      sel_idx_d = pick_idx;
      rw_d      = req_rw[pick_idx];
      w_d       = req_w[int'(pick_idx)*3 +: 3];
      a_d       = req_a[int'(pick_idx)*AW +: AW];
    end

    breql_d = (state_d == BUS_IDLE);
    mreq_d  = sel_v_d & (state_d == BUS_OWN) & ~dbgl;
  end

  // NOTE: state flops use non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q   <= BUS_IDLE;
      ptr_q     <= '0;
      sel_v_q   <= 1'b0;
      sel_idx_q <= '0;
      out_v_q   <= 1'b0;
      owner_q   <= '0;
      rw_q      <= 1'b1;
      w_q       <= '0;
      a_q       <= '0;
      mreq_q    <= 1'b0;
      breql_q   <= 1'b1;
      gnt_q     <= '0;
      done_q    <= '0;
      hold_q    <= HOLD_L;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_v_q   <= sel_v_d;
      sel_idx_q <= sel_idx_d;
      out_v_q   <= out_v_d;
      owner_q   <= owner_d;
      rw_q      <= rw_d;
      w_q       <= w_d;
      a_q       <= a_d;
      mreq_q    <= mreq_d;
      breql_q   <= breql_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign mreq  = mreq_q;
  assign rw    = rw_q;
  assign w     = w_q;
  assign a     = a_q;
  assign breql = breql_q;
  assign owner = 2'(owner_q);
  assign busy  = sel_v_q | out_v_q;
  assign err   = err_q;

endmodule

// File: tb/tb_j_jmem_arb.sv
// Directed bench for j_jmem_arb: single read, round-robin, back-to-back,
// hold-off, bus loss, watchdog and mid-transfer reset.
module tb_j_jmem_arb;
  import j_jmem_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 24;

  logic              clk = 1'b0;
  logic              resetl;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rw;
  logic [3*NREQ-1:0] req_w;
  logic [AW*NREQ-1:0] req_a;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              mreq;
  logic              rw;
  logic [2:0]        w;
  logic [AW-1:0]     a;
  logic              ack;
  logic              dbgl;
  logic              breql;
  logic [1:0]        owner;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  j_jmem_arb #(.NREQ(NREQ), .AW(AW), .HOLD(4), .TMO(8)) dut (
    .clk    (clk),
    .resetl (resetl),
    .req    (req),
    .req_rw (req_rw),
    .req_w  (req_w),
    .req_a  (req_a),
    .gnt    (gnt),
    .done   (done),
    .mreq   (mreq),
    .rw     (rw),
    .w      (w),
    .a      (a),
    .ack    (ack),
    .dbgl   (dbgl),
    .breql  (breql),
    .owner  (owner),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic r, input logic [2:0] wc, input logic [AW-1:0] ad);
    req_rw[k]        = r;
    req_w[3*k +: 3]  = wc;
    req_a[AW*k +: AW] = ad;
  endtask

  initial begin
    resetl = 1'b0;
    req    = '0;
    req_rw = '0;
    req_w  = '0;
    req_a  = '0;
    ack    = 1'b0;
    dbgl   = 1'b1;

    // Reset values
    step();
    chk("rst_mreq",  32'(mreq),  32'd0);
    chk("rst_rw",    32'(rw),    32'd1);
    chk("rst_w",     32'(w),     32'd0);
    chk("rst_a",     32'(a),     32'd0);
    chk("rst_gnt",   32'(gnt),   32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_breql", 32'(breql), 32'd1);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    step();
    resetl = 1'b1;

    // Single read from load/store
    set_slot(RQ_LDST, 1'b1, 3'd2, 24'hF1B000);
    req[RQ_LDST] = 1'b1;
    step();
    chk("sr_breql_low", 32'(breql), 32'd0);
    chk("sr_mreq_e1",   32'(mreq),  32'd0);
    chk("sr_busy_e1",   32'(busy),  32'd1);
    step();
    step();
    dbgl = 1'b0;
    chk("sr_mreq_e3",   32'(mreq),  32'd0);
    step();
    chk("sr_mreq_e4",   32'(mreq),  32'd1);
    chk("sr_a",         32'(a),     32'h00F1B000);
    chk("sr_rw",        32'(rw),    32'd1);
    chk("sr_w",         32'(w),     32'd2);
    ack = 1'b1;
    step();
    chk("sr_gnt",       32'(gnt),   32'b010);
    chk("sr_owner",     32'(owner), 32'd1);
    chk("sr_mreq_drop", 32'(mreq),  32'd0);
    req = '0;
    ack = 1'b0;
    step();
    chk("sr_gnt_clr",   32'(gnt),   32'd0);
    chk("sr_done_early", 32'(done), 32'd0);
    ack = 1'b1;
    step();
    chk("sr_done",      32'(done),  32'b010);
    chk("sr_busy_clr",  32'(busy),  32'd0);
    ack = 1'b0;

    // Hold-off: breql rises exactly four cycles after done
    step();
    chk("hold_done_clr", 32'(done), 32'd0);
    chk("hold_c1",      32'(breql), 32'd0);
    step();
    step();
    chk("hold_c3",      32'(breql), 32'd0);
    step();
    chk("hold_c4",      32'(breql), 32'd1);
    dbgl = 1'b1;

    resetl = 1'b0;
    step();
    resetl = 1'b1;

    // Round-robin with all three held high
    set_slot(RQ_FETCH, 1'b1, 3'd1, 24'h000A00);
    set_slot(RQ_LDST,  1'b0, 3'd3, 24'h000B11);
    set_slot(RQ_BLK,   1'b1, 3'd5, 24'h000C22);
    dbgl = 1'b0;
    ack  = 1'b1;
    req  = 3'b111;
    step();
    chk("rr_mreq_f1", 32'(mreq), 32'd0);
    chk("rr_a_f1",    32'(a),    32'h000A00);
    step();
    chk("rr_mreq_f2", 32'(mreq), 32'd1);
    chk("rr_rw_f2",   32'(rw),   32'd1);
    chk("rr_w_f2",    32'(w),    32'd1);
    step();
    chk("rr_gnt0",    32'(gnt),  32'b001);
    chk("rr_owner0",  32'(owner), 32'd0);
    chk("rr_mreq_f3", 32'(mreq), 32'd0);
    step();
    chk("rr_done0",   32'(done), 32'b001);
    chk("rr_gnt_f4",  32'(gnt),  32'd0);
    chk("rr_a_f4",    32'(a),    32'h000B11);
    chk("rr_rw_f4",   32'(rw),   32'd0);
    chk("rr_w_f4",    32'(w),    32'd3);
    step();
    chk("rr_gnt1",    32'(gnt),  32'b010);
    chk("rr_owner1",  32'(owner), 32'd1);
    step();
    chk("rr_done1",   32'(done), 32'b010);
    chk("rr_a_f6",    32'(a),    32'h000C22);
    step();
    chk("rr_gnt2",    32'(gnt),  32'b100);
    chk("rr_owner2",  32'(owner), 32'd2);
    step();
    chk("rr_done2",   32'(done), 32'b100);
    chk("rr_a_f8",    32'(a),    32'h000A00);
    step();
    chk("rr_gnt0b",   32'(gnt),  32'b001);

    // Back-to-back: done[0] and gnt[2] on the same cycle
    req = 3'b100;
    ack = 1'b0;
    step();
    chk("b2b_mreq",   32'(mreq), 32'd1);
    chk("b2b_a",      32'(a),    32'h000C22);
    chk("b2b_done_wait", 32'(done), 32'd0);
    ack = 1'b1;
    step();
    chk("b2b_gnt2",   32'(gnt),  32'b100);
    chk("b2b_done0",  32'(done), 32'b001);
    chk("b2b_owner",  32'(owner), 32'd2);
    chk("b2b_busy",   32'(busy), 32'd1);
    req = '0;
    step();
    chk("b2b_done2",  32'(done), 32'b100);
    ack = 1'b0;

    // Hold interrupted on cycle 3, with the bus lost while the selection waits
    step();
    step();
    req[RQ_LDST] = 1'b1;
    dbgl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("loss_mreq",  32'(mreq),  32'd0);
      chk("loss_breql", 32'(breql), 32'd0);
      chk("loss_busy",  32'(busy),  32'd1);
      chk("loss_a",     32'(a),     32'h000B11);
    end
    dbgl = 1'b0;
    step();
    chk("loss_mreq_back", 32'(mreq), 32'd1);
    ack = 1'b1;
    step();
    chk("wd_gnt1",  32'(gnt),   32'b010);
    chk("wd_owner", 32'(owner), 32'd1);
    req = '0;
    ack = 1'b0;

    // Watchdog: err after eight stuck cycles
    for (int i = 0; i < 7; i++) step();
    chk("wd_err_c7", 32'(err), 32'd0);
    step();
    chk("wd_err_c8", 32'(err), 32'd1);
    chk("wd_busy",   32'(busy), 32'd1);

    // Reset mid-transfer
    #3;
    resetl = 1'b0;
    #1;
    chk("mrst_breql", 32'(breql), 32'd1);
    chk("mrst_err",   32'(err),   32'd0);
    chk("mrst_mreq",  32'(mreq),  32'd0);
    chk("mrst_busy",  32'(busy),  32'd0);
    chk("mrst_done",  32'(done),  32'd0);
    ack = 1'b1;
    #2;
    resetl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_done", 32'(done), 32'd0);
      chk("mrst_no_gnt",  32'(gnt),  32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/j_jmem_arb.md
Name: j_jmem_arb

Overview:
- Arbiter and sequencer in front of the DSP external-memory state machine, which owns mreq/rw/w/ack/dbgl.
- Shares that single master port between NREQ internal requesters: instruction prefetch, load/store and block-move.
- Owns the bus request to the system arbiter: raises breql, waits for dbgl, and releases the bus after an idle hold-off.
- Issues one transfer at a time, reports per-requester grant and done pulses, and runs a watchdog on stuck cycles.

Parameters:
- NREQ, 3, number of requesters (2..4).
- AW, 24, address width.
- HOLD, 4, idle cycles with bus owned and nothing pending before breql is released.
- TMO, 255, cycles an accepted transfer may wait for completion ack before err is raised; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- resetl  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request, held high until that requester's gnt pulse.
- req_rw  in  NREQ  per-requester direction: 1 = read, 0 = write.
- req_w  in  3*NREQ  per-requester 3-bit width code, passed through opaque.
- req_a  in  AW*NREQ  per-requester address.
- gnt  out  NREQ  one-cycle pulse: this requester's transfer was accepted.
- done  out  NREQ  one-cycle pulse: this requester's transfer completed.
- mreq  out  1  transfer request to the memory state machine.
- rw  out  1  registered direction of the selected transfer.
- w  out  3  registered width code of the selected transfer.
- a  out  AW  registered address of the selected transfer.
- ack  in  1  memory state machine is idle or finishing; a new cycle may be accepted.
- dbgl  in  1  bus grant, active low.
- breql  out  1  bus request, active low.
- owner  out  2  index of the outstanding requester.
- busy  out  1  a selection or a transfer is outstanding.
- err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, resetl low), all registered:
  - mreq=0, rw=1, w=0, a=0, gnt=0, done=0, breql=1, owner=0, busy=0, err=0.
  - Round-robin pointer ptr=0; sel_v=0; out_v=0; hold counter=HOLD; watchdog counter=0.
- Reset asserted mid-transfer aborts everything: no done is produced and nothing is replayed.
- Bus states:
  - IDLE: breql=1. Moves to REQ when any req, sel_v or out_v is set.
  - REQ: breql=0. Moves to OWN on the first edge that samples dbgl=0.
  - OWN: breql=0. A cycle with no req, sel_v or out_v decrements the hold counter; any activity reloads it to HOLD. At 0 the block moves to IDLE.
  - In OWN, dbgl returning to 1 does not change state. mreq is gated low while dbgl=1; sel_v and out_v are kept.
- Selection (any state):
  - Fires when sel_v=0 and some req bit k is set and k is neither out_v's owner nor already granted.
  - Winner is the first set bit scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - The winner's rw, w and a are loaded into the output registers and sel_v is set.
  - Selection takes one cycle: a request first sampled at edge N gives mreq=1 after edge N at the earliest.
- mreq = sel_v & (bus state OWN) & ~dbgl, registered from next-state logic so it is glitch-free.
- Acceptance is an edge with mreq=1 and ack=1. On that edge:
  - gnt[sel] pulses in the following cycle.
  - owner<=sel, out_v<=1, sel_v<=0, ptr<=(sel+1) mod NREQ, watchdog counter cleared.
- Completion is the first edge after acceptance with out_v=1 and ack=1.
  - done[owner] pulses in the following cycle and out_v clears.
  - If a new acceptance lands on the same edge, done goes to the old owner and out_v stays set with owner updated to the new requester (back-to-back).
- A requester may drop req after gnt and re-raise it at any time. A re-raised req is not eligible until its previous done has pulsed.
- At most one gnt bit and one done bit are high in any cycle; gnt and done for different requesters may coincide.
- Watchdog, when TMO≠0:
  - The counter increments each cycle that out_v=1 and ack=0, saturating.
  - Reaching TMO sets err, which stays set until reset. Arbitration carries on unchanged.
- busy = sel_v | out_v.
- Widths:
  - ptr and owner are clog2(NREQ) bits, zero-extended onto the 2-bit owner port.
  - The watchdog counter is 8 bits.
  - The hold counter is clog2(HOLD+1) bits.

Decomposition:
- Shared package j_jmem_pkg holds:
  - bus-state enum (IDLE/REQ/OWN);
  - NREQ_MAX=4;
  - requester index constants RQ_FETCH=0, RQ_LDST=1, RQ_BLK=2.
- One sub-module j_rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are a valid bit and the winner index. It is reused by the GPU-side arbiter.

Test Plan:
- Single read: req[1]=1, rw=1, a=0x00F1B000, dbgl returns 0 two cycles after breql=0, ack pulses.
  - Expect breql=0 one cycle after req, then mreq=1 with a=0x00F1B000, then gnt[1], then done[1] exactly one cycle after the second ack edge.
- Round-robin: req=3'b111 held from ptr=0, ack always 1.
  - Expect grant order 0,1,2,0; gnt one-hot; issue cadence one accept every two cycles.
- Back-to-back: completion of requester 0 on the same edge as acceptance of requester 2.
  - Expect done[0] and gnt[2] in the same cycle, then owner=2.
- Bus loss: dbgl=1 for 5 cycles while sel_v=1.
  - Expect mreq=0 throughout, the selection kept, and mreq=1 again one cycle after dbgl=0.
- Hold and release: last done, no requests, HOLD=4.
  - Expect breql to rise exactly 4 cycles later; a req arriving on cycle 3 instead keeps breql=0.
- Watchdog and reset: ack stuck at 0 after acceptance with TMO=8.
  - Expect err=1 on the 8th cycle; then resetl low mid-cycle gives breql=1, err=0, mreq=0 and no done.
